// File: rtl/wam_hit_scorer_pkg.sv
// Shared constants and the judge state type for the whack-a-mole hit scorer.
package wam_pkg;

  localparam int NUM_MOLES      = 9;
  localparam int IDX_W          = 4;
  localparam int MISS_W         = 4;
  localparam int MAX_MISSES_DEF = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    HIT_WAIT = 2'd2,
    OVER     = 2'd3
  } judge_state_e;

endpackage

// File: rtl/wam_hit_scorer_if.sv
// Handshake between the mole-light stage (master) and the hit scorer (slave).
interface wam_hit_scorer_if;
  import wam_pkg::*;

  logic             mole_up;
  logic [IDX_W-1:0] mole_idx;
  logic             mole_clear;

  modport master (output mole_up, output mole_idx, input  mole_clear);
  modport slave  (input  mole_up, input  mole_idx, output mole_clear);
endinterface

// File: rtl/wam_hit_scorer_whack_sync_edge.sv
// Synchronises the raw whack buttons and emits a one-cycle event per rising edge.
module whack_sync_edge #(
  parameter int WIDTH  = 9,
  parameter int STAGES = 2
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] evt
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]             prev_q;

  // NOTE: the synchroniser and edge flops are reset so no phantom edge appears when reset lifts.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= '0;
      evt    <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage shift on the same edge.
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
      evt    <= sync_q[STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/wam_hit_scorer.sv
// Judges each mole light as hit or miss, keeps saturating score/miss counts and game_over.
module wam_hit_scorer
  import wam_pkg::*;
#(
  parameter int SCORE_W     = 8,
  parameter int MAX_MISSES  = MAX_MISSES_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  wam_hit_scorer_if.slave      light,
  input  logic [NUM_MOLES-1:0] whack,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [SCORE_W-1:0]   score,
  output logic [MISS_W-1:0]    misses,
  output logic                 game_over
);

  logic [NUM_MOLES-1:0] whack_evt;
  logic [NUM_MOLES-1:0] idx_mask;
  logic                 mole_up_q;
  logic                 mole_rise;
  logic                 hit_evt;
  logic                 wrong_evt;
  logic                 at_max;

  judge_state_e         state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SCORE_W-1:0]   score_d;
  logic [MISS_W-1:0]    misses_d;
  logic                 hit_d, miss_d;

  whack_sync_edge #(
    .WIDTH  (NUM_MOLES),
    .STAGES (SYNC_STAGES)
  ) u_whack_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .din      (whack),
    .evt      (whack_evt)
  );

  assign mole_rise = light.mole_up & ~mole_up_q;
  assign idx_mask  = NUM_MOLES'(1) << idx_q;
  assign hit_evt   = |(whack_evt & idx_mask);
  assign wrong_evt = |(whack_evt & ~idx_mask);
  assign at_max    = (misses == MISS_W'(MAX_MISSES));

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    score_d  = score;
    misses_d = misses;
    hit_d    = 1'b0;
    miss_d   = 1'b0;

    if (state_q != OVER && at_max) begin
      state_d = OVER;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Out-of-range light indices never arm the judge.
          if (mole_rise && light.mole_idx < IDX_W'(NUM_MOLES)) begin
            idx_d   = light.mole_idx;
            state_d = ARMED;
          end
        end
        ARMED: begin
          // A correct whack outranks both a wrong whack and the light going out.
          if (hit_evt) begin
            hit_d   = 1'b1;
            state_d = HIT_WAIT;
            if (score != '1) score_d = score + 1'b1;
          end else if (!light.mole_up || wrong_evt) begin
            miss_d   = 1'b1;
            misses_d = misses + 1'b1;
            if (!light.mole_up) state_d = IDLE;
          end
        end
        HIT_WAIT: begin
          if (!light.mole_up) state_d = IDLE;
        end
        OVER: begin
          state_d = OVER;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      mole_up_q        <= 1'b0;
      score            <= '0;
      misses           <= '0;
      hit_pulse        <= 1'b0;
      miss_pulse       <= 1'b0;
      game_over        <= 1'b0;
      light.mole_clear <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      mole_up_q        <= light.mole_up;
      score            <= score_d;
      misses           <= misses_d;
      hit_pulse        <= hit_d;
      miss_pulse       <= miss_d;
      game_over        <= (state_d == OVER);
      light.mole_clear <= (state_d == HIT_WAIT);
    end
  end

endmodule

// File: tb/tb_wam_hit_scorer.sv
// Randomised and directed bench for wam_hit_scorer against a per-mole outcome model.
module tb_wam_hit_scorer;
  import wam_pkg::*;

  localparam int MAXM = 5;

  logic       CLOCK_50;
  logic       reset;
  logic [8:0] whack;

  logic       hit_pulse, miss_pulse, game_over;
  logic [7:0] score;
  logic [3:0] misses;
  logic       hit2, miss2, game_over2;
  logic [1:0] score2;
  logic [3:0] misses2;

  wam_hit_scorer_if light_if ();
  wam_hit_scorer_if light2_if ();
  assign light2_if.mole_up  = light_if.mole_up;
  assign light2_if.mole_idx = light_if.mole_idx;

  wam_hit_scorer #(.SCORE_W(8), .MAX_MISSES(MAXM), .SYNC_STAGES(2)) dut (
    .CLOCK_50 (CLOCK_50), .reset (reset), .light (light_if), .whack (whack),
    .hit_pulse (hit_pulse), .miss_pulse (miss_pulse), .score (score),
    .misses (misses), .game_over (game_over)
  );

  wam_hit_scorer #(.SCORE_W(2), .MAX_MISSES(MAXM), .SYNC_STAGES(2)) dut_narrow (
    .CLOCK_50 (CLOCK_50), .reset (reset), .light (light2_if), .whack (whack),
    .hit_pulse (hit2), .miss_pulse (miss2), .score (score2),
    .misses (misses2), .game_over (game_over2)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: outcome of each mole from the order of whacks it receives.
  int m_hits, m_misses, exp_hit_n, exp_miss_n;
  bit m_over, m_armed;
  int hit_n, miss_n, hit2_n, miss2_n, both_n;

  logic [19:0] act_status;
  assign act_status = {score, score2, misses, misses2, game_over, game_over2};

  always @(negedge CLOCK_50) begin
    if (reset === 1'b1) begin
      hit_n   += int'(hit_pulse);
      miss_n  += int'(miss_pulse);
      hit2_n  += int'(hit2);
      miss2_n += int'(miss2);
      if ((hit_pulse && miss_pulse) || (hit2 && miss2)) both_n++;
    end
  end

  function automatic logic [19:0] exp_status();
    int s1, s2;
    s1 = (m_hits > 255) ? 255 : m_hits;
    s2 = (m_hits > 3) ? 3 : m_hits;
    return {8'(s1), 2'(s2), 4'(m_misses), 4'(m_misses), m_over, m_over};
  endfunction

  function automatic bit counts_bad();
    return (hit_n != exp_hit_n) || (miss_n != exp_miss_n) ||
           (hit2_n != exp_hit_n) || (miss2_n != exp_miss_n) || (both_n != 0);
  endfunction

  function automatic void model_clear();
    m_hits = 0; m_misses = 0; m_over = 0; m_armed = 0;
    exp_hit_n = 0; exp_miss_n = 0;
    hit_n = 0; miss_n = 0; hit2_n = 0; miss2_n = 0; both_n = 0;
  endfunction

  function automatic void model_miss();
    m_misses++;
    exp_miss_n++;
    if (m_misses == MAXM) begin
      m_over  = 1;
      m_armed = 0;
    end
  endfunction

  function automatic void model_whack(input logic [3:0] idx, input logic [8:0] mask);
    if (m_armed && mask != '0) begin
      if (mask[idx]) begin
        m_hits++;
        exp_hit_n++;
        m_armed = 0;
      end else begin
        model_miss();
      end
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    whack = '0;
    light_if.mole_up  = 1'b0;
    light_if.mole_idx = '0;
    tick(2);
    reset = 1'b1;
    tick(2);
    model_clear();
  endtask

  task automatic run_mole(input logic [3:0] idx, input int n, input logic [2:0][8:0] masks);
    light_if.mole_idx = idx;
    light_if.mole_up  = 1'b1;
    m_armed = !m_over && (idx < 4'd9);
    tick(2);
    for (int k = 0; k < n; k++) begin
      whack = masks[k];
      tick(2);
      whack = '0;
      tick(5);
      model_whack(idx, masks[k]);
    end
    light_if.mole_up = 1'b0;
    tick(3);
    if (m_armed) begin
      m_armed = 0;
      model_miss();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (act_status !== 20'd0 || light_if.mole_clear !== 1'b0 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: status=%h clear=%b hit=%b miss=%b, want all 0",
               act_status, light_if.mole_clear, hit_pulse, miss_pulse);
    end
  endtask

  task automatic test_hit_latency();
    logic [2:0] seen;
    do_reset();
    light_if.mole_idx = 4'd3;
    light_if.mole_up  = 1'b1;
    tick(2);
    whack = 9'h008;
    tick(1);
    whack = '0;
    tick(1); seen[0] = hit_pulse;
    tick(1); seen[1] = hit_pulse;
    tick(1); seen[2] = hit_pulse;
    m_hits = 1; exp_hit_n = 1;
    n_cmp++;
    if (seen !== 3'b100 || score !== 8'd1 || light_if.mole_clear !== 1'b1) begin
      n_err++;
      $display("FAIL hit_latency: pulse_seq=%b score=%0d clear=%b, want 100 1 1", seen, score, light_if.mole_clear);
    end
    tick(5);
    n_cmp++;
    if (light_if.mole_clear !== 1'b1 || hit_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL clear_hold: clear=%b hit=%b, want 1 0", light_if.mole_clear, hit_pulse);
    end
    light_if.mole_up = 1'b0;
    tick(1);
    n_cmp++;
    if (light_if.mole_clear !== 1'b0) begin
      n_err++;
      $display("FAIL clear_drop: clear=%b, want 0", light_if.mole_clear);
    end
    tick(2);
    n_cmp++;
    if (act_status !== exp_status() || counts_bad()) begin
      n_err++;
      $display("FAIL hit_totals: status=%h hits=%0d misses=%0d, want status=%h hits=%0d misses=%0d",
               act_status, hit_n, miss_n, exp_status(), exp_hit_n, exp_miss_n);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    light_if.mole_idx = 4'd5;
    light_if.mole_up  = 1'b1;
    tick(100);
    light_if.mole_up = 1'b0;
    tick(1);
    n_cmp++;
    if (miss_pulse !== 1'b1 || misses !== 4'd1 || score !== 8'd0) begin
      n_err++;
      $display("FAIL timeout: miss=%b misses=%0d score=%0d, want 1 1 0", miss_pulse, misses, score);
    end
    tick(2);
    m_misses = 1; exp_miss_n = 1;
    n_cmp++;
    if (act_status !== exp_status() || counts_bad()) begin
      n_err++;
      $display("FAIL timeout_totals: status=%h hits=%0d misses=%0d, want status=%h hits=%0d misses=%0d",
               act_status, hit_n, miss_n, exp_status(), exp_hit_n, exp_miss_n);
    end
  endtask

  task automatic test_priority();
    logic [2:0][8:0] masks;
    do_reset();
    masks = '0;
    masks[0] = 9'h084;
    run_mole(4'd2, 1, masks);
    n_cmp++;
    if (act_status !== exp_status() || counts_bad() || misses !== 4'd0) begin
      n_err++;
      $display("FAIL hit_beats_wrong: status=%h misses=%0d, want status=%h misses=0", act_status, misses, exp_status());
    end
    masks[0] = 9'h080;
    masks[1] = 9'h004;
    run_mole(4'd2, 2, masks);
    n_cmp++;
    if (act_status !== exp_status() || counts_bad()) begin
      n_err++;
      $display("FAIL wrong_stays_armed: status=%h hits=%0d misses=%0d, want status=%h hits=%0d misses=%0d",
               act_status, hit_n, miss_n, exp_status(), exp_hit_n, exp_miss_n);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] p;
    do_reset();
    for (int w = 0; w < 2; w++) begin
      light_if.mole_idx = 4'd4;
      light_if.mole_up  = 1'b1;
      tick(2);
      whack = (w == 0) ? 9'h010 : 9'h040;
      tick(1);
      whack = '0;
      tick(2);
      light_if.mole_up = 1'b0;
      tick(1);
      p = {hit_pulse, miss_pulse};
      if (w == 0) begin m_hits++; exp_hit_n++; end
      else        begin m_misses++; exp_miss_n++; end
      n_cmp++;
      if (p !== ((w == 0) ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL fall_same_cycle_%0d: hit,miss=%b, want %b", w, p, (w == 0) ? 2'b10 : 2'b01);
      end
      tick(4);
    end
    n_cmp++;
    if (act_status !== exp_status() || counts_bad()) begin
      n_err++;
      $display("FAIL simultaneous_totals: status=%h hits=%0d misses=%0d, want status=%h hits=%0d misses=%0d",
               act_status, hit_n, miss_n, exp_status(), exp_hit_n, exp_miss_n);
    end
  endtask

  task automatic test_game_over();
    logic [2:0][8:0] masks;
    do_reset();
    masks = '0;
    for (int i = 0; i < MAXM; i++) run_mole(4'd5, 0, masks);
    tick(2);
    n_cmp++;
    if (act_status !== exp_status() || counts_bad() || game_over !== 1'b1) begin
      n_err++;
      $display("FAIL game_over: status=%h over=%b, want status=%h over=1", act_status, game_over, exp_status());
    end
    masks[0] = 9'h008;
    masks[1] = 9'h002;
    run_mole(4'd3, 2, masks);
    run_mole(4'd1, 0, masks);
    n_cmp++;
    if (act_status !== exp_status() || counts_bad()) begin
      n_err++;
      $display("FAIL over_frozen: status=%h hits=%0d misses=%0d, want status=%h hits=%0d misses=%0d",
               act_status, hit_n, miss_n, exp_status(), exp_hit_n, exp_miss_n);
    end
    #4 reset = 1'b0;
    #1;
    n_cmp++;
    if (act_status !== 20'd0 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || light_if.mole_clear !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_over: status=%h, want 0", act_status);
    end
    tick(1);
    reset = 1'b1;
    tick(2);
    model_clear();
    light_if.mole_idx = 4'd1;
    light_if.mole_up  = 1'b1;
    tick(2);
    whack = 9'h002;
    tick(1);
    whack = '0;
    tick(4);
    n_cmp++;
    if (light_if.mole_clear !== 1'b1 || score !== 8'd1) begin
      n_err++;
      $display("FAIL hit_wait_entry: clear=%b score=%0d, want 1 1", light_if.mole_clear, score);
    end
    #4 reset = 1'b0;
    #1;
    n_cmp++;
    if (light_if.mole_clear !== 1'b0 || act_status !== 20'd0) begin
      n_err++;
      $display("FAIL async_reset_hit_wait: clear=%b status=%h, want 0 0", light_if.mole_clear, act_status);
    end
    tick(1);
    light_if.mole_up = 1'b0;
    reset = 1'b1;
    tick(2);
    model_clear();
  endtask

  task automatic test_saturation();
    logic [2:0][8:0] masks;
    logic [3:0] idx;
    do_reset();
    masks = '0;
    for (int i = 0; i < 5; i++) begin
      idx = 4'($urandom_range(0, 8));
      masks[0] = 9'h001 << idx;
      run_mole(idx, 1, masks);
    end
    n_cmp++;
    if (score2 !== 2'd3 || act_status !== exp_status() || counts_bad()) begin
      n_err++;
      $display("FAIL score_saturate: narrow=%0d status=%h, want narrow=3 status=%h", score2, act_status, exp_status());
    end
  endtask

  task automatic test_held_whack();
    do_reset();
    light_if.mole_idx = 4'd0;
    light_if.mole_up  = 1'b1;
    tick(2);
    whack = 9'h001;
    tick(6);
    light_if.mole_up = 1'b0;
    tick(3);
    light_if.mole_up = 1'b1;
    tick(10);
    light_if.mole_up = 1'b0;
    tick(3);
    whack = '0;
    tick(3);
    m_hits = 1; exp_hit_n = 1;
    m_misses = 1; exp_miss_n = 1;
    n_cmp++;
    if (act_status !== exp_status() || counts_bad()) begin
      n_err++;
      $display("FAIL held_whack: status=%h hits=%0d misses=%0d, want status=%h hits=%0d misses=%0d",
               act_status, hit_n, miss_n, exp_status(), exp_hit_n, exp_miss_n);
    end
  endtask

  task automatic test_invalid_idx();
    logic [2:0][8:0] masks;
    do_reset();
    masks = '0;
    masks[0] = 9'h001;
    masks[1] = 9'h100;
    run_mole(4'd9, 2, masks);
    run_mole(4'd15, 1, masks);
    masks[0] = 9'h100;
    run_mole(4'd8, 1, masks);
    n_cmp++;
    if (act_status !== exp_status() || counts_bad()) begin
      n_err++;
      $display("FAIL invalid_idx: status=%h hits=%0d misses=%0d, want status=%h hits=%0d misses=%0d",
               act_status, hit_n, miss_n, exp_status(), exp_hit_n, exp_miss_n);
    end
  endtask

  task automatic test_random();
    logic [2:0][8:0] masks;
    logic [3:0] idx;
    logic [8:0] m;
    int n;
    do_reset();
    for (int t = 0; t < 60; t++) begin
      idx = 4'($urandom_range(0, 10));
      n = $urandom_range(0, 3);
      masks = '0;
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 2))
          0: m = (idx < 4'd9) ? (9'h001 << idx) : 9'h001;
          1: begin
            m = 9'($urandom_range(1, 511));
            if (idx < 4'd9) m[idx] = 1'b0;
            if (m == '0) m = (idx == 4'd0) ? 9'h002 : 9'h001;
          end
          default: m = 9'($urandom_range(1, 511));
        endcase
        masks[k] = m;
      end
      run_mole(idx, n, masks);
      n_cmp++;
      if (act_status !== exp_status() || counts_bad()) begin
        n_err++;
        $display("FAIL random_mole_%0d: idx=%0d status=%h hits=%0d misses=%0d, want status=%h hits=%0d misses=%0d",
                 t, idx, act_status, hit_n, miss_n, exp_status(), exp_hit_n, exp_miss_n);
      end
      if (m_over) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_hit_latency();
    test_timeout();
    test_priority();
    test_simultaneous();
    test_game_over();
    test_saturation();
    test_held_whack();
    test_invalid_idx();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
